arbiter_wrr: RTL

- Parametrised weighted round-robin arbiter that succeeds the basic `arbiter`.
- Merges REQ_WIDTH valid/ready streams of DW-bit data into one registered output stream.
- Adds per-requester burst weights, packet locking on a `last` flag, and a full-throughput output register stage.
- Sits between multiple producers and a single shared consumer.

---
 rtl/arbiter_pkg.sv | 27 ++
 rtl/arbiter_rr_pick.sv | 40 ++++
 rtl/arbiter_wrr.sv | 121 ++++++++++++
 3 files changed

// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
// The state record is sized for the largest supported configuration.
package arbiter_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

    localparam int REQ_WIDTH_DEF = 4;
    localparam int ID_W          = clog2(REQ_WIDTH_DEF);
    localparam int ID_MAX        = 8;
    localparam int CRED_MAX      = 16;

    typedef struct packed {
        logic                locked;
        logic                mid_pkt;
        logic [ID_MAX-1:0]   owner;
        logic [CRED_MAX-1:0] credit;
        logic [ID_MAX-1:0]   ptr;
    } arb_state_t;

endpackage

// File: rtl/arbiter_rr_pick.sv
// Round-robin pick: first set request at or after ptr, wrapping.
// Double-width masked priority encoder.
module arbiter_rr_pick
    import arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_onehot_o,
    output logic [IW-1:0] gnt_idx_o,
    output logic          any_o
);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] mask;
    logic [2*N-1:0] masked;
    logic [IW:0]    pos;

    always_comb begin
        dbl    = {req_i, req_i};
        mask   = {(2*N){1'b1}} << ptr_i;
        masked = dbl & mask;
        pos    = '0;
        // Scan downward so the lowest set bit wins.
        for (int j = 2*N - 1; j >= 0; j--) begin
            if (masked[j]) begin
                pos = (IW+1)'(j);
            end
        end
        if (pos >= (IW+1)'(N)) begin
            pos = pos - (IW+1)'(N);
        end
        any_o        = |req_i;
        gnt_idx_o    = pos[IW-1:0];
        gnt_onehot_o = any_o ? (N'(1) << gnt_idx_o) : '0;
    end

endmodule

// File: rtl/arbiter_wrr.sv
// Weighted round-robin stream arbiter with packet locking
// and a full-throughput registered output stage.
module arbiter_wrr
    import arbiter_pkg::*;
#(
    parameter int REQ_WIDTH = REQ_WIDTH_DEF,
    parameter int DW        = 8,
    parameter int WW        = 4,
    localparam int IW       = clog2(REQ_WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [REQ_WIDTH-1:0]    valid_in,
    input  logic [REQ_WIDTH*DW-1:0] data_in,
    input  logic [REQ_WIDTH-1:0]    last_in,
    input  logic [REQ_WIDTH*WW-1:0] weight_in,
    input  logic                    ready_in,
    output logic [REQ_WIDTH-1:0]    ready_out,
    output logic                    valid_out,
    output logic [DW-1:0]           data_out,
    output logic                    last_out,
    output logic [IW-1:0]           grant_id_out
);

    arb_state_t st_q, st_d;
    logic          valid_q, valid_d;
    logic          last_q, last_d;
    logic [DW-1:0] data_q, data_d;
    logic [IW-1:0] gid_q, gid_d;

    logic [REQ_WIDTH-1:0] pick_oh;
    logic [IW-1:0]        pick_idx;
    logic                 pick_any;
    logic [IW-1:0]        owner, ptr, gnt, nxt;
    logic                 gnt_ok, out_free, xfer;
    logic [WW-1:0]        wgt, cred;
    logic                 unused_hi;

    assign owner     = st_q.owner[IW-1:0];
    assign ptr       = st_q.ptr[IW-1:0];
    assign unused_hi = ^{st_q.owner, st_q.ptr, st_q.credit};

    arbiter_rr_pick #(.N(REQ_WIDTH), .IW(IW)) u_pick (
        .req_i        (valid_in),
        .ptr_i        (ptr),
        .gnt_onehot_o (pick_oh),
        .gnt_idx_o    (pick_idx),
        .any_o        (pick_any)
    );

    always_comb begin
        out_free = !valid_q || ready_in;
        gnt      = st_q.locked ? owner : pick_idx;
        gnt_ok   = st_q.locked || pick_any;
        nxt      = (gnt == IW'(REQ_WIDTH - 1)) ? '0 : gnt + 1'b1;
        xfer     = gnt_ok && out_free && valid_in[gnt] && !rst;
        ready_out = '0;
        if (gnt_ok && out_free && !rst) begin
            ready_out = st_q.locked ? (REQ_WIDTH'(1) << owner) : pick_oh;
        end

        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        gid_d   = gid_q;
        st_d    = st_q;
        // Weight is only sampled when a burst starts.
        wgt  = weight_in[int'(gnt)*WW +: WW];
        cred = st_q.locked ? st_q.credit[WW-1:0]
                           : ((wgt == '0) ? WW'(1) : wgt);

        if (xfer) begin
            valid_d      = 1'b1;
            data_d       = data_in[int'(gnt)*DW +: DW];
            last_d       = last_in[gnt];
            gid_d        = gnt;
            st_d.locked  = 1'b1;
            st_d.owner   = ID_MAX'(gnt);
            st_d.mid_pkt = !last_in[gnt];
            if (last_in[gnt]) begin
                cred = cred - 1'b1;
            end
            st_d.credit = CRED_MAX'(cred);
            if (last_in[gnt] && cred == '0) begin
                st_d.locked = 1'b0;
                st_d.ptr    = ID_MAX'(nxt);
            end
        end else begin
            if (out_free) begin
                valid_d = 1'b0;
            end
            // Owner idle between packets gives up the rest of its turn.
            if (st_q.locked && !st_q.mid_pkt && !valid_in[owner]) begin
                st_d.locked = 1'b0;
                st_d.ptr    = ID_MAX'(nxt);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            gid_q   <= '0;
        end else begin
            st_q    <= st_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            gid_q   <= gid_d;
        end
    end

    assign valid_out    = valid_q;
    assign data_out     = data_q;
    assign last_out     = last_q;
    assign grant_id_out = gid_q;

endmodule
